uart_rec: RTL
=============

UART_REC -- requirements
Module: uart_rec

Interface
REQ-001 SHALL provide parameter packetSize, default 16, number of data bits per bitstream frame.
REQ-002 SHALL provide parameter cycleDiv, default 100, clk cycles per bit period.
REQ-003 SHALL provide parameter propDelayOffset, default 0, whole bit periods to skip between frame start and the first data bit.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rstN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide port bsIn  input  1  serial bitstream from the transmitter, LSB first.
REQ-007 SHALL provide port sendSig  input  1  frame-start alert from the transmitter.
REQ-008 SHALL provide port dataOut  output  packetSize  last completely received word.
REQ-009 SHALL provide port dataValid  output  1  one-clk pulse when dataOut updates.
REQ-010 SHALL provide port busy  output  1  high while a frame is in progress (WAIT or RECV).
REQ-011 SHALL provide port overrun  output  1  sticky flag, set when sendSig rises during a frame.

Function
REQ-012 SHALL register sendSig once and detect a rising edge as sendSig=1 with the previous sample=0.
REQ-013 SHALL implement states IDLE, WAIT, RECV and DONE.
REQ-014 SHALL leave IDLE on a detected sendSig edge, clear the bit counter and the cycle counter, and enter WAIT if propDelayOffset>0, else RECV.
REQ-015 SHALL run the cycle counter 0..cycleDiv-1 and wrap it to 0; each wrap ends one bit period.
REQ-016 SHALL stay in WAIT for exactly propDelayOffset bit periods, then enter RECV with the cycle counter at 0.
REQ-017 SHALL sample bsIn in RECV when the cycle counter equals cycleDiv/2 (integer division), mid-bit.
REQ-018 SHALL shift each sample into the MSB of the internal shift register with a right shift, so the first received bit lands in bit 0 after packetSize samples.
REQ-019 SHALL enter DONE on the cycle after the packetSize-th sample.
REQ-020 SHALL, in DONE, load dataOut from the shift register, assert dataValid for exactly one cycle, and return to IDLE on the next cycle.
REQ-021 SHALL set the first data sample N+propDelayOffset*cycleDiv+cycleDiv/2+1 cycles after the edge is detected at cycle N, with later samples spaced cycleDiv cycles apart.
REQ-022 SHALL hold dataOut unchanged at all times other than DONE.
REQ-023 SHALL ignore a sendSig held high continuously, which yields exactly one frame per rising edge.
REQ-024 SHALL NOT restart the frame on a sendSig edge in WAIT or RECV; it SHALL set overrun instead.
REQ-025 SHALL clear overrun only by reset.
REQ-026 SHALL accept a sendSig edge in DONE as a new frame start and not count it as an overrun.
REQ-027 SHALL drive busy=1 exactly in WAIT and RECV.
REQ-028 SHALL require cycleDiv>=2 and packetSize>=1, with elaboration failure otherwise.

Reset
REQ-029 SHALL, while rstN=0, immediately force state IDLE and clear both counters, the shift register and the sendSig history register.
REQ-030 SHALL, while rstN=0, immediately force dataOut=0, dataValid=0, busy=0 and overrun=0.
REQ-031 SHALL discard any partial frame when reset asserts mid-frame, produce no dataValid, and leave dataOut=0.
REQ-032 SHALL not treat sendSig already high at reset release as an edge.

Verification
REQ-033 SHALL pass this scenario: packetSize=8, cycleDiv=4, offset=0, send 0xA5 LSB first -> dataOut=0xA5, with a single dataValid 1+8*4 cycles after the edge-detect cycle.
REQ-034 SHALL pass this scenario: offset=2 with the same frame 0x3C -> first sample delayed by exactly 8 cycles relative to offset=0, and dataOut=0x3C.
REQ-035 SHALL pass this scenario: sendSig held high for 100 cycles -> exactly one dataValid pulse and overrun=0.
REQ-036 SHALL pass this scenario: second sendSig edge during RECV -> frame completes with the original data and overrun=1 until reset.
REQ-037 SHALL pass this scenario: rstN pulled low after 3 bits -> outputs 0 immediately, no dataValid, and the next full frame 0xFF is received correctly.
REQ-038 SHALL pass this scenario: back-to-back frames 0x01 then 0x80 with the second edge in DONE -> two dataValid pulses with dataOut 0x01 then 0x80.

Source files
------------

// File: rtl/uart_rec.sv
// uart_rec: receives one fixed-length serial word per sendSig rising edge.
// Bits arrive LSB first; each is sampled at the middle of its bit period.
// The finished word is presented on dataOut together with a one-cycle dataValid.
module uart_rec #(
  parameter int packetSize      = 16,
  parameter int cycleDiv        = 100,
  parameter int propDelayOffset = 0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  bsIn,
  input  logic                  sendSig,
  output logic [packetSize-1:0] dataOut,
  output logic                  dataValid,
  output logic                  busy,
  output logic                  overrun
);

  // Refuse to build with parameters the timing scheme cannot honour.
  if (cycleDiv < 2 || packetSize < 1 || propDelayOffset < 0) begin : gBadParams
    $error("uart_rec: requires cycleDiv >= 2, packetSize >= 1, propDelayOffset >= 0");
  end

  // The bit counter is shared between WAIT, which counts offset periods,
  // and RECV, which counts data bits, so it is sized for the larger of the two.
  localparam int CycW   = $clog2(cycleDiv);
  localparam int CntMax = (packetSize > propDelayOffset) ? packetSize : propDelayOffset;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CycW-1:0] CycLast  = CycW'(cycleDiv - 1);
  localparam logic [CycW-1:0] CycHalf  = CycW'(cycleDiv / 2);
  localparam logic [CycW-1:0] CycOne   = CycW'(1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] BitLast  = CntW'(packetSize - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'((propDelayOffset > 0) ? propDelayOffset - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  // A frame starts in WAIT only when there are offset periods to skip.
  localparam state_e FirstState = (propDelayOffset > 0) ? WAIT : RECV;

  state_e                  state_q, state_d;
  logic [CycW-1:0]         cycCnt_q, cycCnt_d;
  logic [CntW-1:0]         bitCnt_q, bitCnt_d;
  logic [packetSize-1:0]   shiftReg_q, shiftReg_d;
  logic [packetSize-1:0]   dataOut_q, dataOut_d;
  logic                    dataValid_q, dataValid_d;
  logic                    overrun_q, overrun_d;
  logic                    sendSigPrev_q;
  logic                    armed_q;
  logic                    sendEdge;
  logic                    cycWrap;

  // armed_q blocks the first cycle after reset so that a sendSig already high
  // at release is not mistaken for a rising edge.
  assign sendEdge = armed_q & sendSig & ~sendSigPrev_q;
  assign cycWrap  = (cycCnt_q == CycLast);

  // sendSig history used for rising-edge detection.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sendSigPrev_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      sendSigPrev_q <= sendSig;
      armed_q       <= 1'b1;
    end
  end

  // Frame sequencing: next state, counters, shift register and output words.
  always_comb begin
    state_d     = state_q;
    cycCnt_d    = cycCnt_q;
    bitCnt_d    = bitCnt_q;
    shiftReg_d  = shiftReg_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        if (sendEdge) begin
          state_d  = FirstState;
          cycCnt_d = '0;
          bitCnt_d = '0;
        end
      end

      WAIT: begin
        cycCnt_d = cycWrap ? '0 : cycCnt_q + CycOne;
        if (sendEdge) begin
          overrun_d = 1'b1;
        end
        if (cycWrap) begin
          if (bitCnt_q == WaitLast) begin
            state_d  = RECV;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CntOne;
          end
        end
      end

      RECV: begin
        cycCnt_d = cycWrap ? '0 : cycCnt_q + CycOne;
        if (sendEdge) begin
          overrun_d = 1'b1;
        end
        if (cycCnt_q == CycHalf) begin
          shiftReg_d                 = shiftReg_q >> 1;
          shiftReg_d[packetSize-1]   = bsIn;
          if (bitCnt_q == BitLast) begin
            state_d = DONE;
          end else begin
            bitCnt_d = bitCnt_q + CntOne;
          end
        end
      end

      DONE: begin
        dataOut_d   = shiftReg_q;
        dataValid_d = 1'b1;
        state_d     = IDLE;
        if (sendEdge) begin
          state_d  = FirstState;
          cycCnt_d = '0;
          bitCnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cycCnt_q    <= '0;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycCnt_q    <= cycCnt_d;
      bitCnt_q    <= bitCnt_d;
      shiftReg_q  <= shiftReg_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dataOut   = dataOut_q;
  assign dataValid = dataValid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == WAIT) || (state_q == RECV);

endmodule
